instr_encoder: RTL

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder.sv | 125 ++++++++++++
 1 files changed

// File: rtl/instr_encoder.sv
// Instruction encoder: accepts decoded op fields, encodes them into 32-bit MIPS-style
// words and writes them sequentially into an instruction memory.
module instr_encoder #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              prog_en,
  input  logic              prog_clear,
  input  logic              op_valid,
  output logic              op_ready,
  input  logic [3:0]        op_kind,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [5:0]        funct,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e            state_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [ADDR_W:0]   count_q;
  logic              err_q;

  logic              legal;
  logic [31:0]       word;
  logic              hs;

  always_comb begin
    legal = 1'b1;
    word  = '0;
    unique case (op_kind)
      4'd0:  word = '0;
      4'd1:  word = {6'h00, rs, rt, rd, shamt, funct};
      4'd2:  word = {6'h1C, rs, rt, rd, shamt, funct};
      4'd3:  word = {6'h02, target};
      4'd4:  word = {6'h04, rs, rt, imm};
      4'd5:  word = {6'h05, rs, rt, imm};
      4'd6:  word = {6'h08, rs, rt, imm};
      4'd7:  word = {6'h23, rs, rt, imm};
      4'd8:  word = {6'h21, rs, rt, imm};
      4'd9:  word = {6'h20, rs, rt, imm};
      4'd10: word = {6'h2B, rs, rt, imm};
      4'd11: word = {6'h29, rs, rt, imm};
      4'd12: word = {6'h28, rs, rt, imm};
      default: legal = 1'b0;
    endcase
  end

  assign op_ready = rst_n & prog_en & (state_q == IDLE);
  assign hs       = op_valid & op_ready;

  // The write pointer is the low part of count; the counter is cleared on every exit
  // path that rewinds the memory, so the two never diverge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (prog_clear) begin
            count_q <= '0;
          end else if (hs) begin
            if (legal) begin
              wdata_q <= word;
              addr_q  <= count_q[ADDR_W-1:0];
              we_q    <= 1'b1;
              state_q <= WRITE;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        WRITE: begin
          we_q <= 1'b0;
          if (prog_clear) begin
            count_q <= '0;
            state_q <= IDLE;
          end else begin
            count_q <= count_q + 1'b1;
            state_q <= (addr_q == '1) ? FULL : IDLE;
          end
        end
        FULL: begin
          if (prog_clear) begin
            count_q <= '0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Strobe is masked while reset is held so a write caught by reset never reaches memory.
  assign imem_we    = we_q & rst_n;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign count      = count_q;
  assign full       = (state_q == FULL);
  assign err        = err_q;

endmodule
